// File: rtl/adc_pkg.sv
// Constants and state encoding shared by the ADC responder and the ADC controller.
package adc_pkg;

  localparam int DATA_W         = 12;
  localparam int NUM_CH         = 8;
  localparam int FRAME_BITS     = 16;
  localparam int ADDR_W         = 3;
  // Rising-edge counts (before increment) on which the next address is sampled, MSB first.
  localparam int ADDR_FIRST_BIT = 2;
  localparam int ADDR_LAST_BIT  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/adc_responder_if.sv
// Serial ADC bus: the initiator drives clock, select and address; the responder returns data.
interface adc_responder_if;

  logic ADC_SCLK;
  logic ADC_CS_N;
  logic ADC_SADDR;
  logic ADC_SDAT;

  modport master (output ADC_SCLK, output ADC_CS_N, output ADC_SADDR, input ADC_SDAT);
  modport slave  (input ADC_SCLK, input ADC_CS_N, input ADC_SADDR, output ADC_SDAT);

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit, with single-cycle rise/fall strobes.
module sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{IDLE_VAL}};
      prev  <= IDLE_VAL;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value, forming a real chain.
      chain <= STAGES'({chain, d});
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/adc_responder.sv
// Emulates a serial multi-channel ADC: serves the addressed channel's snapshot MSB first and
// collects the address for the following frame from ADC_SADDR.
module adc_responder #(
  parameter int DATA_W      = adc_pkg::DATA_W,
  parameter int NUM_CH      = adc_pkg::NUM_CH,
  parameter int FRAME_BITS  = adc_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  adc_responder_if.slave           adc,
  input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
  output logic                     FRAME_DONE,
  output logic                     FRAME_ERR,
  output logic [2:0]               CUR_ADDR
);

  import adc_pkg::*;

  localparam int CNT_W   = $clog2(FRAME_BITS + 1);
  localparam int FLUSH_W = SYNC_STAGES + 1;
  localparam logic [CNT_W-1:0] LAST_RISE = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_LO   = CNT_W'(ADDR_FIRST_BIT);
  localparam logic [CNT_W-1:0] ADDR_HI   = CNT_W'(ADDR_LAST_BIT);

  state_t                 state, state_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [2:0]             addr_next;
  logic [SYNC_STAGES-1:0] saddr_sync;
  logic [FLUSH_W-1:0]     flush;
  logic                   armed;
  logic                   sclk_q, sclk_rise, sclk_fall;
  logic                   cs_q, cs_rise, cs_fall;
  logic                   saddr, frame_full;
  logic                   start, done_next, err_next;
  logic [DATA_W-1:0]      ch [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch[k] = CH_DATA[k*DATA_W +: DATA_W];
  end

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sclk (
    .clk(CLOCK), .rst_n(RESET_N), .d(adc.ADC_SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
    .clk(CLOCK), .rst_n(RESET_N), .d(adc.ADC_CS_N), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  assign saddr      = saddr_sync[SYNC_STAGES-1];
  assign frame_full = (bit_cnt == FULL);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no branch can infer a latch.
    state_next = state;
    start      = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        // A CS_N rise wins over any coincident SCLK edge.
        if (cs_rise) begin
          state_next = IDLE;
          err_next   = !frame_full;
        end else if (sclk_rise && bit_cnt == LAST_RISE) begin
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      saddr_sync <= '0;
      flush      <= '0;
      armed      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      addr_next  <= '0;
      CUR_ADDR   <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      saddr_sync <= SYNC_STAGES'({saddr_sync, adc.ADC_SADDR});
      flush      <= FLUSH_W'({flush, 1'b1});
      // Frames are accepted only once a genuinely idle bus has been seen after reset, so a
      // select held low through reset cannot masquerade as a fresh falling edge.
      if (flush[FLUSH_W-1] && cs_q && sclk_q) armed <= 1'b1;
      FRAME_DONE <= done_next;
      FRAME_ERR  <= err_next;
      if (start) begin
        bit_cnt <= '0;
        shreg   <= FRAME_BITS'(ch[CUR_ADDR]);
      end else if (state == ACTIVE && !cs_rise && !frame_full) begin
        if (sclk_fall) shreg <= shreg << 1;
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt >= ADDR_LO && bit_cnt <= ADDR_HI) addr_next <= {addr_next[1:0], saddr};
        end
      end
      if (done_next) CUR_ADDR <= addr_next;
    end
  end

  assign adc.ADC_SDAT = (state == ACTIVE) && !frame_full && shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_adc_responder.sv
// Randomized scoreboard bench for adc_responder: an initiator model drives frames and queues the
// expected outcome; a monitor compares each FRAME_DONE/FRAME_ERR pulse with the serial bits seen.
module tb_adc_responder;

  import adc_pkg::*;

  localparam int HALF = 8;

  typedef struct {
    bit          is_err;
    logic [15:0] word;
    int          nbits;
    logic [2:0]  addr;
  } exp_t;

  logic                     CLOCK;
  logic                     RESET_N;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     FRAME_DONE, FRAME_ERR;
  logic [2:0]               CUR_ADDR;

  adc_responder_if bus ();

  adc_responder #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_BITS(FRAME_BITS), .SYNC_STAGES(2)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .adc(bus), .CH_DATA(ch_data),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .CUR_ADDR(CUR_ADDR)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic        rx_bits[$];
  logic [11:0] ch_m [NUM_CH];
  logic [2:0]  cur_addr_m;
  exp_t        mon_e;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge CLOCK);
  endtask

  task automatic drive_ch();
    for (int i = 0; i < NUM_CH; i++) ch_data[i*DATA_W +: DATA_W] = ch_m[i];
  endtask

  task automatic scramble_ch();
    for (int i = 0; i < NUM_CH; i++) ch_m[i] = ch_m[i] ^ 12'($urandom_range(1, 4095));
    drive_ch();
  endtask

  // One initiator frame: n_rise SCLK cycles; mutate changes CH_DATA mid-frame;
  // reset_at > 0 pulses RESET_N for one cycle in that bit's low phase.
  task automatic run_frame(input logic [2:0] addr, input int n_rise, input bit mutate,
                           input int reset_at);
    exp_t e;
    e.is_err = (n_rise < FRAME_BITS);
    e.nbits  = e.is_err ? n_rise : FRAME_BITS;
    e.word   = 16'(ch_m[cur_addr_m]);
    e.addr   = e.is_err ? cur_addr_m : addr;
    if (reset_at == 0) exp_q.push_back(e);
    bus.ADC_CS_N = 1'b0;
    half();
    for (int k = 1; k <= n_rise; k++) begin
      bus.ADC_SCLK  = 1'b0;
      bus.ADC_SADDR = (k == 3) ? addr[2] : (k == 4) ? addr[1] : (k == 5) ? addr[0]
                                         : 1'($urandom_range(0, 1));
      if (mutate && k == 6) scramble_ch();
      if (k == reset_at) begin
        @(negedge CLOCK); RESET_N = 1'b0;
        @(negedge CLOCK); RESET_N = 1'b1;
        cur_addr_m = 3'd0;
        repeat (4) @(negedge CLOCK);
        check("sdat_after_reset", 32'(bus.ADC_SDAT), 32'd0);
        check("addr_after_reset", 32'(CUR_ADDR), 32'd0);
        check("done_after_reset", 32'(FRAME_DONE), 32'd0);
        check("err_after_reset", 32'(FRAME_ERR), 32'd0);
      end
      half();
      bus.ADC_SCLK = 1'b1;
      half();
    end
    bus.ADC_CS_N  = 1'b1;
    bus.ADC_SADDR = 1'b0;
    if (!e.is_err && reset_at == 0) cur_addr_m = addr;
    half();
    half();
  endtask

  // Serial sniffer: the initiator reads SDAT while SCLK is high, i.e. just before each fall.
  always @(negedge bus.ADC_CS_N) rx_bits.delete();
  always @(negedge bus.ADC_SCLK) if (bus.ADC_CS_N === 1'b0) rx_bits.push_back(bus.ADC_SDAT);
  always @(posedge bus.ADC_CS_N)
    for (int i = FRAME_BITS; i < rx_bits.size(); i++) check("tail_bit_zero", 32'(rx_bits[i]), 32'd0);

  // Monitor: every status pulse consumes one queued expectation.
  always @(negedge CLOCK) begin
    if (FRAME_DONE === 1'b1 || FRAME_ERR === 1'b1) begin
      check("pulse_was_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [15:0] got_w, mask;
        mon_e = exp_q.pop_front();
        got_w = '0;
        mask  = '0;
        for (int i = 0; i < mon_e.nbits && i < 16; i++) begin
          mask[15-i] = 1'b1;
          if (i < rx_bits.size()) got_w[15-i] = rx_bits[i];
        end
        check("frame_done", 32'(FRAME_DONE), 32'(!mon_e.is_err));
        check("frame_err", 32'(FRAME_ERR), 32'(mon_e.is_err));
        check("bit_count", 32'(rx_bits.size()), 32'(mon_e.nbits));
        check("serial_word", 32'(got_w), 32'(mon_e.word & mask));
        check("cur_addr", 32'(CUR_ADDR), 32'(mon_e.addr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N       = 1'b0;
    bus.ADC_SCLK  = 1'b1;
    bus.ADC_CS_N  = 1'b1;
    bus.ADC_SADDR = 1'b0;
    cur_addr_m    = 3'd0;
    for (int i = 0; i < NUM_CH; i++) ch_m[i] = 12'($urandom);
    ch_m[0] = 12'hABC;
    drive_ch();
    repeat (3) @(negedge CLOCK);
    check("reset_sdat", 32'(bus.ADC_SDAT), 32'd0);
    check("reset_done", 32'(FRAME_DONE), 32'd0);
    check("reset_err", 32'(FRAME_ERR), 32'd0);
    check("reset_addr", 32'(CUR_ADDR), 32'd0);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLOCK);

    run_frame(3'b000, 16, 1'b0, 0);          // CH0 = 0xABC
    run_frame(3'b101, 16, 1'b0, 0);          // still CH0, selects ch5
    check("addr_after_select", 32'(CUR_ADDR), 32'd5);
    ch_m[5] = 12'h123;
    drive_ch();
    run_frame(3'b101, 16, 1'b0, 0);          // 0x0123
    run_frame(3'b010, 9, 1'b0, 0);           // aborted: error, address kept
    check("addr_after_abort", 32'(CUR_ADDR), 32'd5);
    run_frame(3'b011, 16, 1'b1, 0);          // old ch5 served despite mid-frame change
    run_frame(3'b110, 16, 1'b0, 7);          // reset during bit 7
    run_frame(3'b001, 16, 1'b0, 0);          // ch0 after reset
    run_frame(3'b100, 20, 1'b0, 0);          // overlong window, tail reads zero

    for (int f = 0; f < 10; f++) begin
      int sel, n;
      sel = $urandom_range(0, 3);
      n   = (sel == 0) ? $urandom_range(0, 15) : (sel == 3) ? $urandom_range(17, 24) : 16;
      run_frame(3'($urandom_range(0, 7)), n, 1'($urandom_range(0, 1)), 0);
    end

    check("idle_sdat", 32'(bus.ADC_SDAT), 32'd0);
    repeat (30) @(negedge CLOCK);
    check("no_missing_pulses", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the sample width per channel.
REQ-002 Parameter NUM_CH, default 8, SHALL set the number of emulated channels.
REQ-003 Parameter FRAME_BITS, default 16, SHALL set the SCLK rising edges per complete frame.
REQ-004 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on SCLK, CS_N and SADDR.
REQ-005 CLOCK  input  1  SHALL be the single system clock; all logic is clocked on its rising edge.
REQ-006 RESET_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 ADC_SCLK  input  1  SHALL be the serial clock driven by the initiator (asynchronous to CLOCK).
REQ-008 ADC_CS_N  input  1  SHALL be the active-low frame select from the initiator.
REQ-009 ADC_SADDR  input  1  SHALL be the serial address/command bit from the initiator.
REQ-010 ADC_SDAT  output  1  SHALL be the serial sample data returned to the initiator, MSB first.
REQ-011 CH_DATA  input  NUM_CH*DATA_W  SHALL hold the emulated channel values, channel k in bits [k*DATA_W +: DATA_W].
REQ-012 FRAME_DONE  output  1  SHALL be a one-CLOCK pulse on completion of a full frame.
REQ-013 FRAME_ERR  output  1  SHALL be a one-CLOCK pulse when CS_N deasserts mid-frame.
REQ-014 CUR_ADDR  output  3  SHALL be the channel address that will be served in the next frame.

Function
REQ-015 SCLK, CS_N and SADDR SHALL each pass through SYNC_STAGES flops before use; edges SHALL be detected on the synchronized values.
REQ-016 The FSM SHALL have two states: IDLE (synchronized CS_N high) and ACTIVE (frame in progress).
REQ-017 IDLE -> ACTIVE on the CS_N falling edge: bit_cnt <= 0; shift register <= {(FRAME_BITS-DATA_W) zeros, CH_DATA[CUR_ADDR]} (snapshot; later CH_DATA changes SHALL NOT affect the frame).
REQ-018 ADC_SDAT SHALL equal the shift-register MSB in ACTIVE and 0 in IDLE.
REQ-019 On each synchronized SCLK falling edge in ACTIVE, the shift register SHALL shift left by one and fill with 0.
REQ-020 On each synchronized SCLK rising edge in ACTIVE, bit_cnt SHALL increment; SADDR SHALL be captured into addr_next[2], [1], [0] on rising edges 3, 4, 5 (bit_cnt 2, 3, 4 before increment).
REQ-021 On the FRAME_BITS-th rising edge: CUR_ADDR <= addr_next, FRAME_DONE pulses once, bit_cnt saturates.
REQ-022 SCLK edges after FRAME_BITS rising edges while CS_N stays low SHALL be ignored; SDAT SHALL be 0.
REQ-023 CS_N rising in ACTIVE before FRAME_BITS rising edges: FRAME_ERR pulses, CUR_ADDR unchanged, return to IDLE.
REQ-024 CS_N rising after a complete frame: return to IDLE, no pulse.
REQ-025 Simultaneous synchronized CS_N rise and SCLK edge: CS_N takes priority; the SCLK edge is discarded.
REQ-026 SDAT SHALL update within SYNC_STAGES+2 CLOCK cycles of an SCLK falling edge; correct operation requires SCLK half-period >= SYNC_STAGES+3 CLOCK cycles.
REQ-027 SCLK edges in IDLE SHALL have no effect.

Reset
REQ-028 While RESET_N is low at a CLOCK edge: state = IDLE, bit_cnt = 0, shift register = 0, addr_next = 0, CUR_ADDR = 0, ADC_SDAT = 0, FRAME_DONE = 0, FRAME_ERR = 0, synchronizers loaded with idle levels (SCLK 1, CS_N 1, SADDR 0).
REQ-029 Reset asserted mid-frame SHALL abort without FRAME_ERR; after release, the first frame starts only on a fresh CS_N falling edge.

Structure
REQ-030 Package adc_pkg SHALL hold FRAME_BITS, DATA_W, NUM_CH, the address bit positions (2..4) and the IDLE/ACTIVE state enum, shared with the existing ADC controller.
REQ-031 One sub-module, sync_edge (SYNC_STAGES flop synchronizer plus rise/fall pulse outputs), SHALL be instantiated for SCLK and CS_N; SADDR uses the synchronizer only.

Verification
REQ-032 Reset, CH0=0xABC, frame with SADDR bits 000 -> SDAT 0000_1010_1011_1100, FRAME_DONE once, CUR_ADDR=0.
REQ-033 Frame 1 addressing ch5 (SADDR 101), frame 2 with CH5=0x123 -> frame 1 returns CH0, frame 2 returns 0000_0001_0010_0011, CUR_ADDR=5 after frame 1.
REQ-034 CS_N raised after 9 rising edges -> FRAME_ERR one pulse, no FRAME_DONE, CUR_ADDR unchanged, next frame serves the old channel.
REQ-035 CH_DATA changed mid-frame -> serialized word equals the value at CS_N fall.
REQ-036 RESET_N low for 1 cycle during bit 7 -> SDAT=0, CUR_ADDR=0, no pulses; next full frame correct.
REQ-037 20 SCLK cycles in one CS_N window -> bits 17-20 read 0, exactly one FRAME_DONE.
